// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Write-side front end for a synchronous register file. N_REQ producers each
// offer one write at a time over a valid/ready handshake. A round-robin
// arbiter picks at most one per cycle and the winner's address/data are
// registered onto a single register-file write port. Addresses at or above
// N_REG are consumed but not forwarded; they raise a one-cycle addr_err
// pulse instead.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   freeze     1 = issue no new grants (a write already registered still shows)
//   req_valid  per-requester "write pending"
//   req_ready  one-hot (or zero) grant, combinational from the current inputs
//   req_addr   per-requester write address
//   req_data   per-requester write data
//   waddr      registered write address to the register file
//   wen        registered write enable, one pulse per accepted in-range write
//   wdata      registered write data to the register file
//   addr_err   registered one-cycle pulse for an accepted out-of-range write
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REG = 32,
    parameter int N_REQ = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  freeze,
    input  logic [N_REQ-1:0]                      req_valid,
    output logic [N_REQ-1:0]                      req_ready,
    input  logic [N_REQ-1:0][$clog2(N_REG)-1:0]   req_addr,
    input  logic [N_REQ-1:0][WIDTH-1:0]           req_data,
    output logic [$clog2(N_REG)-1:0]              waddr,
    output logic                                  wen,
    output logic [WIDTH-1:0]                      wdata,
    output logic                                  addr_err
);

    localparam int AW = $clog2(N_REG);
    // Pointer width; a single requester still gets a 1-bit pointer that
    // simply never leaves 0.
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]    ptr_q,      ptr_d;
    logic             wen_q,      wen_d;
    logic [AW-1:0]    waddr_q,    waddr_d;
    logic [WIDTH-1:0] wdata_q,    wdata_d;
    logic             addr_err_q, addr_err_d;

    // -------------------------------------------------------------------------
    // Round-robin grant
    //
    // Requesters at or above the pointer form the "upper" group. If any of
    // them is valid the lowest one wins; otherwise the search wraps and the
    // lowest valid requester overall wins. That is exactly the search
    // ptr, ptr+1, ..., wrapping modulo N_REQ, without a modulo in hardware.
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] valid_hi;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic             grant_any;
    logic [PW-1:0]    ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (PW'(gi) >= ptr_q);
            assign valid_hi[gi]   = req_valid[gi] & upper_mask[gi];
        end
    endgenerate

    always_comb begin
        cand      = (|valid_hi) ? valid_hi : req_valid;
        grant_idx = '0;
        // Descending scan so the lowest set index is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant_idx = PW'(i);
            end
        end
        // No grant at all while in reset or frozen.
        grant_any = (|req_valid) & ~rst & ~freeze;
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == PW'(gi));
        end
    endgenerate

    assign req_ready = grant;

    // Pointer moves to the requester just after the winner.
    assign ptr_next = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);

    // -------------------------------------------------------------------------
    // Winner's address/data. AND-OR mux driven by the one-hot grant, so the
    // selection never indexes past N_REQ-1 for non-power-of-two N_REQ.
    // -------------------------------------------------------------------------
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             sel_in_range;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i];
                sel_data = sel_data | req_data[i];
            end
        end
    end

    // When N_REG fills the whole address field every encodable address is
    // legal, so the range check collapses to a constant.
    generate
        if (N_REG == (1 << AW)) begin : g_full_range
            assign sel_in_range = 1'b1;
        end else begin : g_partial_range
            localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(N_REG);
            assign sel_in_range = ({1'b0, sel_addr} < ADDR_LIMIT);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state: write port and pointer
    //
    // wen/addr_err are pulses and default low; waddr/wdata/ptr hold unless a
    // handshake happens. An out-of-range request still moves the pointer,
    // since it has been consumed.
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_d      = ptr_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        addr_err_d = 1'b0;
        if (grant_any) begin
            ptr_d = ptr_next;
            if (sel_in_range) begin
                wen_d   = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign wen      = wen_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wr_arbiter (WIDTH=32, N_REG=20, N_REQ=4).
// Directed scenarios compare against constant expectations; the random
// scenario compares against a reference model that searches for the next
// requester with modulo arithmetic and tracks the write port as plain
// variables.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int WIDTH = 32;
    localparam int N_REG = 20;
    localparam int N_REQ = 4;
    localparam int AW    = $clog2(N_REG);

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         freeze;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][AW-1:0]     req_addr;
    logic [N_REQ-1:0][WIDTH-1:0]  req_data;
    logic [AW-1:0]                waddr;
    logic                         wen;
    logic [WIDTH-1:0]             wdata;
    logic                         addr_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_ptr = 0;
    logic        m_wen = 1'b0;
    logic        m_err = 1'b0;
    logic [AW-1:0]    m_waddr = '0;
    logic [WIDTH-1:0] m_wdata = '0;
    int          m_last_grant = -1;

    regfile_wr_arbiter #(
        .WIDTH (WIDTH),
        .N_REG (N_REG),
        .N_REQ (N_REQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .waddr     (waddr),
        .wen       (wen),
        .wdata     (wdata),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    // Which requester the rules say wins right now (-1 = none).
    function automatic int m_pick();
        if (rst || freeze) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] m_ready();
        logic [N_REQ-1:0] r;
        int g;
        r = '0;
        g = m_pick();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock edge and move the model along with it. Returns at
    // posedge+1 so registered outputs are settled.
    task automatic tick();
        int g;
        g = m_pick();
        @(posedge clk);
        if (rst) begin
            m_wen = 1'b0; m_err = 1'b0; m_waddr = '0; m_wdata = '0; m_ptr = 0;
        end else if (g >= 0) begin
            if (int'(req_addr[g]) < N_REG) begin
                m_wen = 1'b1; m_err = 1'b0;
                m_waddr = req_addr[g]; m_wdata = req_data[g];
            end else begin
                m_wen = 1'b0; m_err = 1'b1;
            end
            m_ptr = (g + 1) % N_REQ;
            $display("txn t=%0t req=%0d addr=%0d data=%h %s", $time, g,
                     req_addr[g], req_data[g],
                     (int'(req_addr[g]) < N_REG) ? "write" : "addr_err");
        end else begin
            m_wen = 1'b0; m_err = 1'b0;
        end
        m_last_grant = g;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; req_valid = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; req_valid = '1;
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i] = AW'(i); req_data[i] = WIDTH'(i);
        end
        tick(); tick();
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        n_checks++; if (wen !== 1'b0) begin n_errors++; $display("FAIL reset_wen got=%b want=0", wen); end
        n_checks++; if (waddr !== '0) begin n_errors++; $display("FAIL reset_waddr got=%0d want=0", waddr); end
        n_checks++; if (wdata !== '0) begin n_errors++; $display("FAIL reset_wdata got=%h want=0", wdata); end
        n_checks++; if (addr_err !== 1'b0) begin n_errors++; $display("FAIL reset_addr_err got=%b want=0", addr_err); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL reset_first_grant got=%b want=0001", req_ready); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_single_requester();
        do_reset();
        req_valid = 4'b0100; req_addr[2] = 5'd5; req_data[2] = 32'hDEADBEEF;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (wen !== 1'b1) begin n_errors++; $display("FAIL single_wen got=%b want=1", wen); end
        n_checks++; if (waddr !== 5'd5) begin n_errors++; $display("FAIL single_waddr got=%0d want=5", waddr); end
        n_checks++; if (wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_wdata got=%h want=deadbeef", wdata); end
        n_checks++; if (addr_err !== 1'b0) begin n_errors++; $display("FAIL single_addr_err got=%b want=0", addr_err); end
        // Pointer should now sit on requester 3.
        req_valid = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL single_ptr got=%b want=1000", req_ready); end
        req_valid = '0;
        tick();
        #1;
        n_checks++; if (wen !== 1'b0) begin n_errors++; $display("FAIL single_idle_wen got=%b want=0", wen); end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] vlist [4];
        int               elist [4];
        vlist = '{4'b1111, 4'b1111, 4'b1011, 4'b1111};
        elist = '{0, 1, 3, 0};
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i] = AW'(i + 1); req_data[i] = WIDTH'(i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++; if (req_ready !== 4'(1 << (c % 4))) begin n_errors++; $display("FAIL rr_ready[%0d] got=%b want=%b", c, req_ready, 4'(1 << (c % 4))); end
            tick();
            n_checks++; if ({wen, wdata} !== {1'b1, WIDTH'(c % 4)}) begin n_errors++; $display("FAIL rr_write[%0d] got wen=%b data=%0d want wen=1 data=%0d", c, wen, wdata, c % 4); end
        end
        for (int j = 0; j < 4; j++) begin
            req_valid = vlist[j];
            #1;
            tick();
            n_checks++; if ({wen, wdata} !== {1'b1, WIDTH'(elist[j])}) begin n_errors++; $display("FAIL rr_drop[%0d] got wen=%b data=%0d want wen=1 data=%0d", j, wen, wdata, elist[j]); end
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_out_of_range();
        do_reset();
        req_valid = 4'b0001; req_addr[0] = 5'd7; req_data[0] = 32'h11;
        #1; tick();
        req_valid = 4'b0010; req_addr[1] = 5'd25; req_data[1] = 32'hBAD;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL oor_ready got=%b want=0010", req_ready); end
        tick();
        n_checks++; if ({addr_err, wen} !== 2'b10) begin n_errors++; $display("FAIL oor25_flags got err=%b wen=%b want err=1 wen=0", addr_err, wen); end
        n_checks++; if ({waddr, wdata} !== {5'd7, 32'h11}) begin n_errors++; $display("FAIL oor25_hold got addr=%0d data=%h want addr=7 data=11", waddr, wdata); end
        // Highest legal address is forwarded normally.
        req_valid = 4'b0100; req_addr[2] = 5'd19; req_data[2] = 32'h22;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL oor_next_ready got=%b want=0100", req_ready); end
        tick();
        n_checks++; if ({addr_err, wen, waddr, wdata} !== {1'b0, 1'b1, 5'd19, 32'h22}) begin n_errors++; $display("FAIL addr19 got err=%b wen=%b addr=%0d data=%h", addr_err, wen, waddr, wdata); end
        // Address equal to N_REG is the first illegal one.
        req_valid = 4'b1000; req_addr[3] = 5'd20; req_data[3] = 32'h33;
        #1; tick();
        n_checks++; if ({addr_err, wen, waddr, wdata} !== {1'b1, 1'b0, 5'd19, 32'h22}) begin n_errors++; $display("FAIL addr20 got err=%b wen=%b addr=%0d data=%h", addr_err, wen, waddr, wdata); end
        req_valid = '0;
        #1; tick();
        n_checks++; if (addr_err !== 1'b0) begin n_errors++; $display("FAIL oor_pulse got=%b want=0", addr_err); end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i] = AW'(i); req_data[i] = WIDTH'(i);
        end
        req_valid = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL frz_pre_ready got=%b want=0001", req_ready); end
        tick();
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL frz_ready[%0d] got=%b want=0000", c, req_ready); end
            n_checks++; if (wen !== (c == 0)) begin n_errors++; $display("FAIL frz_wen[%0d] got=%b want=%b", c, wen, (c == 0)); end
            if (c == 0) begin
                n_checks++; if (wdata !== 32'd0) begin n_errors++; $display("FAIL frz_wdata got=%0d want=0", wdata); end
            end
            tick();
        end
        freeze = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL frz_resume_ready got=%b want=0010", req_ready); end
        tick();
        n_checks++; if ({wen, wdata} !== {1'b1, 32'd1}) begin n_errors++; $display("FAIL frz_resume_write got wen=%b data=%0d want wen=1 data=1", wen, wdata); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i] = AW'(i); req_data[i] = WIDTH'(i);
        end
        req_valid = 4'b1111;
        #1; tick(); tick();
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL mid_ready got=%b want=0100", req_ready); end
        tick();
        rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL mid_rst_ready got=%b want=0000", req_ready); end
        n_checks++; if ({wen, wdata} !== {1'b1, 32'd2}) begin n_errors++; $display("FAIL mid_inflight got wen=%b data=%0d want wen=1 data=2", wen, wdata); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if ({wen, waddr, wdata} !== {1'b0, 5'd0, 32'd0}) begin n_errors++; $display("FAIL mid_cleared got wen=%b addr=%0d data=%0d want 0/0/0", wen, waddr, wdata); end
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL mid_ptr got=%b want=0001", req_ready); end
        tick();
        n_checks++; if ({wen, wdata} !== {1'b1, 32'd0}) begin n_errors++; $display("FAIL mid_restart got wen=%b data=%0d want wen=1 data=0", wen, wdata); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            // Producers: drop a request once consumed, maybe post a new one.
            for (int i = 0; i < N_REQ; i++) begin
                if (i == m_last_grant) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    req_valid[i] = 1'b1;
                    req_addr[i]  = AW'($urandom_range(0, 31));
                    req_data[i]  = $urandom;
                end
            end
            freeze = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 49) == 0);
            #1;
            n_checks++; if (req_ready !== m_ready()) begin n_errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, req_ready, m_ready()); end
            n_checks++; if ({wen, addr_err, waddr, wdata} !== {m_wen, m_err, m_waddr, m_wdata}) begin n_errors++; $display("FAIL rand_port[%0d] got wen=%b err=%b addr=%0d data=%h want wen=%b err=%b addr=%0d data=%h", c, wen, addr_err, waddr, wdata, m_wen, m_err, m_waddr, m_wdata); end
            tick();
        end
        rst = 1'b0; freeze = 1'b0; req_valid = '0;
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_single_requester();
        test_round_robin();
        test_out_of_range();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Write-side front end for the synchronous register files.
- Accepts write requests from N_REQ independent producers over per-requester valid/ready handshakes.
- Round-robin arbitrates them and drives a single register-file write port (waddr/wen/wdata) from registered outputs.
- Flags out-of-range addresses instead of forwarding them.

Parameters:
- WIDTH, 32, width of each register / write data.
- N_REG, 32, number of registers in the target register file (any value >= 2; need not be a power of two).
- N_REQ, 4, number of requesters (>= 1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- freeze  input  1  when 1, no new grants are issued (in-flight registered write still completes).
- req_valid  input  [N_REQ-1:0]  requester i has a write pending.
- req_ready  output  [N_REQ-1:0]  one-hot (or zero) grant; handshake on req_valid[i] & req_ready[i].
- req_addr  input  [N_REQ-1:0][$clog2(N_REG)-1:0]  write address per requester.
- req_data  input  [N_REQ-1:0][WIDTH-1:0]  write data per requester.
- waddr  output  $clog2(N_REG)  register-file write address (registered).
- wen  output  1  register-file write enable (registered, one-cycle pulse per accepted write).
- wdata  output  WIDTH  register-file write data (registered).
- addr_err  output  1  registered one-cycle pulse: an accepted request had req_addr >= N_REG.

Behaviour:
- Reset (rst=1 at a clock edge): wen=0, waddr=0, wdata=0, addr_err=0, priority pointer ptr=0.
- During any cycle with rst=1, req_ready=0; no handshake occurs.
- Grant (combinational, same cycle):
  - If rst=0 and freeze=0, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - req_ready has at most one bit set; it is 0 when no valid or when freeze=1.
  - req_ready[i] never asserts without req_valid[i].
- Accept (at the clock edge where handshake on requester g occurs, g = granted index):
  - If req_addr[g] < N_REG: next cycle wen=1, waddr=req_addr[g], wdata=req_data[g], addr_err=0.
  - Else: next cycle wen=0, addr_err=1, waddr/wdata hold previous values.
  - ptr <= (g+1) mod N_REQ in both cases; out-of-range requests are consumed.
- No handshake at an edge: next cycle wen=0, addr_err=0, waddr/wdata hold, ptr holds.
- Latency: exactly 1 cycle from handshake to wen. Throughput: one write per cycle sustained; no bubbles between back-to-back grants.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles, in index order starting from ptr.
- N_REQ=1: ptr is a constant 0; req_ready[0] = req_valid[0] & ~freeze & ~rst.
- freeze asserted: a write registered on the previous edge still appears (wen=1) this cycle; ptr holds; requesters stall with no data loss (valid held by producer).
- Reset mid-operation: a handshake in the cycle before rst still registers. At the rst edge, all outputs clear, so that write's wen pulse is suppressed if it would fall in the cycle after the rst edge.
- Address width: comparison against N_REG is unsigned on the full $clog2(N_REG)-bit field. For power-of-two N_REG, addr_err never asserts.
- Requesters must hold req_valid/req_addr/req_data stable until handshake; the arbiter does not check this.

Test Plan:
- Reset: rst=1 two cycles with all req_valid=1 -> req_ready=0, wen=0, waddr=0, wdata=0, addr_err=0; first grant after release goes to requester 0.
- Single requester: N_REQ=4; only req_valid[2]=1, req_addr[2]=5, req_data[2]=0xDEADBEEF -> req_ready=4'b0100 same cycle; next cycle wen=1, waddr=5, wdata=0xDEADBEEF; ptr becomes 3.
- Round-robin: all four valid for 8 cycles with req_data[i]=i -> wdata sequence 0,1,2,3,0,1,2,3 on consecutive cycles, wen=1 every cycle; requester 2 alone dropping valid for one cycle gives sequence ...,1,3,...
- Out of range: N_REG=20; req_valid[1]=1, req_addr[1]=25 -> handshake, next cycle addr_err=1, wen=0, waddr/wdata unchanged; next request wins normally.
- Freeze: all valid, assert freeze for 3 cycles after granting requester 0 -> wen=1 (data 0) in first freeze cycle, then wen=0 for 2 cycles, req_ready=0 throughout; after deassert, requester 1 granted.
- Reset mid-stream: continuous grants, rst asserted one cycle -> wen=0 the cycle after the rst edge, ptr=0, next grant to requester 0 after release.
